// File: rtl/pllce_pkg.sv
// Shared types and constants for the PLL clock-enable sequencer.
package pllce_pkg;

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        FILTER    = 2'd1,
        ALIGN     = 2'd2,
        RUN       = 2'd3
    } state_e;

    localparam int CNT_W_DEF = 8;
    localparam int LOSS_W    = 8;

    // Saturating increment for the lock-loss counter.
    function automatic logic [LOSS_W-1:0] sat_inc(input logic [LOSS_W-1:0] v);
        return (v == {LOSS_W{1'b1}}) ? v : v + {{(LOSS_W-1){1'b0}}, 1'b1};
    endfunction

endpackage

// File: rtl/pllce_chan.sv
// One clock-enable channel: divide/phase registers, free-running slot
// counter, phase clamp and strobe decode. The strobe is decoded purely from
// registers (counter, latched config and the registered RUN flag).
module pllce_chan
    import pllce_pkg::*;
#(
    parameter int               CNT_W   = CNT_W_DEF,
    parameter logic [CNT_W-1:0] DIV_RST = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             align,
    input  logic             run,
    input  logic             load,
    input  logic [CNT_W-1:0] div_in,
    input  logic [CNT_W-1:0] phase_in,
    output logic             ce
);

    logic [CNT_W-1:0] div_q;
    logic [CNT_W-1:0] phase_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] phase_eff_s;

    // Configuration registers: take new divide/phase when a load is accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q   <= DIV_RST;
            phase_q <= {CNT_W{1'b0}};
        end else if (load) begin
            div_q   <= div_in;
            phase_q <= phase_in;
        end else begin
            div_q   <= div_q;
            phase_q <= phase_q;
        end
    end

    // Slot counter: zeroed at the shared ALIGN instant, wraps at div in RUN.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= {CNT_W{1'b0}};
        end else if (align) begin
            cnt_q <= {CNT_W{1'b0}};
        end else if (run) begin
            cnt_q <= (cnt_q == div_q) ? {CNT_W{1'b0}}
                                      : cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_q <= cnt_q;
        end
    end

    // Phase clamp and strobe decode; an oversized phase lands on the last slot.
    always_comb begin
        phase_eff_s = phase_q;
        ce          = 1'b0;
        if (phase_q > div_q) begin
            phase_eff_s = div_q;
        end else begin
            phase_eff_s = phase_q;
        end
        if (run && (cnt_q == phase_eff_s)) begin
            ce = 1'b1;
        end else begin
            ce = 1'b0;
        end
    end

endmodule

// File: rtl/pll_ce_sequencer.sv
// PLL clock-enable sequencer: synchronises and filters PLL lock, releases a
// synchronous reset, and drives NUM_CH phase-aligned clock-enable strobes.
// Optional feature macro: PLLCE_LOSS_CNT_EN enables the saturating
// lock-loss counter; without it lock_loss_cnt is tied to zero.
module pll_ce_sequencer
    import pllce_pkg::*;
#(
    parameter int NUM_CH    = 3,
    parameter int CNT_W     = CNT_W_DEF,
    parameter int LOCK_FILT = 16,
    parameter int DIV_RST   = 3
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    pll_locked,
    input  logic [NUM_CH*CNT_W-1:0] cfg_div,
    input  logic [NUM_CH*CNT_W-1:0] cfg_phase,
    input  logic                    cfg_load,
    output logic                    cfg_ack,
    output logic [NUM_CH-1:0]       ce,
    output logic                    ready,
    output logic                    sync_rst_n,
    output logic [LOSS_W-1:0]       lock_loss_cnt
);

    localparam logic [15:0] FILT_LAST = 16'(LOCK_FILT - 1);

    logic [1:0]  sync_q;
    logic        lk_s;
    state_e      state_q, state_d;
    logic [15:0] filt_q, filt_d;
    logic        load_s;
    logic        ack_q;
    logic        ready_q;
    logic        srst_q;
    logic        align_s;
    logic        run_s;

    assign lk_s = sync_q[1];

    // Two-flop synchroniser for the asynchronous PLL lock input.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], pll_locked};
        end
    end

    // Next-state logic: lock filter, alignment and config-load acceptance.
    always_comb begin
        state_d = state_q;
        filt_d  = filt_q;
        load_s  = 1'b0;
        case (state_q)
            WAIT_LOCK: begin
                filt_d = 16'd0;
                load_s = cfg_load;
                if (lk_s) begin
                    state_d = FILTER;
                end else begin
                    state_d = WAIT_LOCK;
                end
            end
            FILTER: begin
                load_s = cfg_load;
                if (!lk_s) begin
                    state_d = WAIT_LOCK;
                    filt_d  = 16'd0;
                end else if (filt_q == FILT_LAST) begin
                    state_d = ALIGN;
                    filt_d  = 16'd0;
                end else begin
                    state_d = FILTER;
                    filt_d  = filt_q + 16'd1;
                end
            end
            ALIGN: begin
                filt_d = 16'd0;
                if (!lk_s) begin
                    state_d = WAIT_LOCK;
                end else begin
                    state_d = RUN;
                end
            end
            RUN: begin
                load_s = cfg_load;
                if (!lk_s) begin
                    state_d = WAIT_LOCK;
                end else if (cfg_load) begin
                    state_d = ALIGN;
                end else begin
                    state_d = RUN;
                end
            end
            default: begin
                state_d = WAIT_LOCK;
                filt_d  = 16'd0;
            end
        endcase
    end

    // State, filter counter and registered status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= WAIT_LOCK;
            filt_q  <= 16'd0;
            ack_q   <= 1'b0;
            ready_q <= 1'b0;
            srst_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            filt_q  <= filt_d;
            ack_q   <= load_s;
            ready_q <= (state_d == RUN);
            srst_q  <= ready_q;
        end
    end

    assign align_s    = (state_q == ALIGN);
    assign run_s      = (state_q == RUN);
    assign cfg_ack    = ack_q;
    assign ready      = ready_q;
    assign sync_rst_n = srst_q;

`ifdef PLLCE_LOSS_CNT_EN
    logic              loss_s;
    logic [LOSS_W-1:0] loss_q;

    assign loss_s = run_s && !lk_s;

    // Saturating count of RUN exits caused by lock loss.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            loss_q <= {LOSS_W{1'b0}};
        end else if (loss_s) begin
            loss_q <= sat_inc(loss_q);
        end else begin
            loss_q <= loss_q;
        end
    end

    assign lock_loss_cnt = loss_q;
`else
    assign lock_loss_cnt = {LOSS_W{1'b0}};
`endif

    for (genvar i = 0; i < NUM_CH; i++) begin : g_chan
        pllce_chan #(
            .CNT_W   (CNT_W),
            .DIV_RST (CNT_W'(DIV_RST))
        ) u_chan (
            .clk      (clk),
            .rst_n    (rst_n),
            .align    (align_s),
            .run      (run_s),
            .load     (load_s),
            .div_in   (cfg_div[i*CNT_W +: CNT_W]),
            .phase_in (cfg_phase[i*CNT_W +: CNT_W]),
            .ce       (ce[i])
        );
    end

endmodule

// File: tb/tb_pll_ce_sequencer.sv
// Self-checking bench for pll_ce_sequencer: directed scenarios plus random
// lock/config traffic, compared every cycle against a slot-arithmetic model.
module tb_pll_ce_sequencer;

    localparam int NUM_CH    = 3;
    localparam int CNT_W     = 8;
    localparam int LOCK_FILT = 16;

    logic                    clk = 1'b0;
    logic                    rst_n;
    logic                    pll_locked;
    logic [NUM_CH*CNT_W-1:0] cfg_div;
    logic [NUM_CH*CNT_W-1:0] cfg_phase;
    logic                    cfg_load;
    logic                    cfg_ack;
    logic [NUM_CH-1:0]       ce;
    logic                    ready;
    logic                    sync_rst_n;
    logic [7:0]              lock_loss_cnt;

    pll_ce_sequencer #(
        .NUM_CH(NUM_CH), .CNT_W(CNT_W), .LOCK_FILT(LOCK_FILT), .DIV_RST(3)
    ) dut (
        .clk(clk), .rst_n(rst_n), .pll_locked(pll_locked),
        .cfg_div(cfg_div), .cfg_phase(cfg_phase), .cfg_load(cfg_load),
        .cfg_ack(cfg_ack), .ce(ce), .ready(ready), .sync_rst_n(sync_rst_n),
        .lock_loss_cnt(lock_loss_cnt)
    );

    always #5 clk = ~clk;

    int total  = 0;
    int passed = 0;
    int failed = 0;
    int acks   = 0;

    // Reference model: lock history, consecutive-lock streak and RUN slot time.
    bit m_s1, m_s2;
    bit m_up, m_align, m_ack, m_srst;
    int m_streak, m_run_t, m_loss;
    int m_div [NUM_CH];
    int m_ph  [NUM_CH];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_s1 = 0; m_s2 = 0; m_up = 0; m_align = 0; m_ack = 0; m_srst = 0;
        m_streak = 0; m_run_t = 0; m_loss = 0;
        for (int i = 0; i < NUM_CH; i++) begin
            m_div[i] = 3;
            m_ph[i]  = 0;
        end
    endtask

    task automatic model_latch();
        for (int i = 0; i < NUM_CH; i++) begin
            m_div[i] = int'(cfg_div[i*CNT_W +: CNT_W]);
            m_ph[i]  = int'(cfg_phase[i*CNT_W +: CNT_W]);
        end
        m_ack = 1;
    endtask

    task automatic compare_all();
        logic [NUM_CH-1:0] exp_ce;
        int pe;
        exp_ce = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            pe = (m_ph[i] > m_div[i]) ? m_div[i] : m_ph[i];
            exp_ce[i] = m_up && ((m_run_t % (m_div[i] + 1)) == pe);
        end
        chk("ce", 32'(ce), 32'(exp_ce));
        chk("ready", 32'(ready), 32'(m_up));
        chk("sync_rst_n", 32'(sync_rst_n), 32'(m_srst));
        chk("cfg_ack", 32'(cfg_ack), 32'(m_ack));
        chk("lock_loss_cnt", 32'(lock_loss_cnt), 32'(m_loss));
    endtask

    task automatic tick();
        bit lk;
        bit ld;
        @(posedge clk);
        lk   = m_s2;
        m_s2 = m_s1;
        m_s1 = pll_locked;
        ld   = cfg_load;
        m_srst = m_up;
        m_ack  = 0;
        if (m_up) begin
            if (ld) model_latch();
            if (!lk) begin
                m_up = 0;
                m_streak = 0;
`ifdef PLLCE_LOSS_CNT_EN
                if (m_loss < 255) m_loss++;
`endif
            end else if (ld) begin
                m_up = 0;
                m_align = 1;
            end else begin
                m_run_t++;
            end
        end else if (m_align) begin
            m_align = 0;
            m_streak = 0;
            if (lk) begin
                m_up = 1;
                m_run_t = 0;
            end
        end else begin
            if (ld) model_latch();
            if (lk) begin
                m_streak++;
                if (m_streak == LOCK_FILT + 1) begin
                    m_align = 1;
                    m_streak = 0;
                end
            end else begin
                m_streak = 0;
            end
        end
        #1;
        compare_all();
        if (cfg_ack === 1'b1) acks++;
        if (cfg_load && cfg_ack === 1'b1) cfg_load = 1'b0;
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        while (ready !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
    endtask

    task automatic async_reset();
        #3;
        rst_n = 1'b0;
        cfg_load = 1'b0;
        #1;
        model_reset();
        compare_all();
        @(posedge clk);
        #1;
        compare_all();
        rst_n = 1'b1;
    endtask

    initial begin
        int n;
        int hits;
        int hsum;
        int exp_sat;

        rst_n = 1'b0; pll_locked = 1'b0; cfg_load = 1'b0;
        cfg_div = '0; cfg_phase = '0;
        model_reset();
        #2;
        compare_all();
        @(posedge clk); #1;
        rst_n = 1'b1;
        tick();

        // Configure while waiting for lock: div={3,3,3}, phase={0,1,0}.
        cfg_div   = {8'd3, 8'd3, 8'd3};
        cfg_phase = {8'd0, 8'd1, 8'd0};
        cfg_load  = 1'b1;
        tick();
        tick();

        // Lock acquisition latency.
        pll_locked = 1'b1;
        wait_ready(n);
        chk("lock_latency", 32'(n), 32'd20);
        tick();
        chk("sync_rst_follow", 32'(sync_rst_n), 32'd1);
        repeat (24) tick();

        // Lock drop in RUN: ready falls three edges after the raw drop.
        pll_locked = 1'b0;
        n = 0;
        while (ready === 1'b1 && n < 20) begin
            tick();
            n++;
        end
        chk("drop_latency", 32'(n), 32'd3);
        chk("drop_ce", 32'(ce), 32'd0);
        tick();
        chk("drop_sync_rst", 32'(sync_rst_n), 32'd0);

        // Glitch at filter count 10 restarts the full filter.
        pll_locked = 1'b1;
        n = 0;
        while (m_streak != 11 && n < 50) begin
            tick();
            n++;
        end
        pll_locked = 1'b0;
        tick();
        pll_locked = 1'b1;
        wait_ready(n);
        chk("filter_restart", 32'(n), 32'd20);
        repeat (10) tick();

        // Reconfigure in RUN: div0=9, phase0=20 clamps to slot 9.
        cfg_div   = {8'd3, 8'd3, 8'd9};
        cfg_phase = {8'd0, 8'd1, 8'd20};
        cfg_load  = 1'b1;
        tick();
        chk("run_load_ack", 32'(cfg_ack), 32'd1);
        chk("align_ce", 32'(ce), 32'd0);
        hits = 0; hsum = 0;
        for (int t = 0; t < 30; t++) begin
            tick();
            if (ce[0] === 1'b1) begin
                hits++;
                hsum += t;
            end
        end
        chk("clamp_hits", 32'(hits), 32'd3);
        chk("clamp_slots", 32'(hsum), 32'd57);

        // Load together with a lock loss: one ack, new config from first RUN cycle.
        acks = 0;
        cfg_div   = {8'd0, 8'd1, 8'd1};
        cfg_phase = {8'd5, 8'd1, 8'd0};
        cfg_load  = 1'b1;
        pll_locked = 1'b0;
        repeat (5) tick();
        pll_locked = 1'b1;
        wait_ready(n);
        chk("first_run_ce", 32'(ce), 32'b101);
        repeat (5) tick();
        chk("single_ack", 32'(acks), 32'd1);

        // Random lock and configuration traffic.
        for (int c = 0; c < 1500; c++) begin
            if (!cfg_load && $urandom_range(0, 5) == 0) begin
                for (int i = 0; i < NUM_CH; i++) begin
                    cfg_div[i*CNT_W +: CNT_W]   = 8'($urandom_range(0, 15));
                    cfg_phase[i*CNT_W +: CNT_W] = 8'($urandom_range(0, 20));
                end
                cfg_load = 1'b1;
            end
            if (pll_locked && $urandom_range(0, 59) == 0) pll_locked = 1'b0;
            else if (!pll_locked && $urandom_range(0, 2) == 0) pll_locked = 1'b1;
            tick();
        end
        while (cfg_load) tick();

        // Repeated lock losses for counter saturation.
        pll_locked = 1'b1;
        wait_ready(n);
        for (int k = 0; k < 258; k++) begin
            pll_locked = 1'b0;
            repeat (4) tick();
            pll_locked = 1'b1;
            wait_ready(n);
            chk("relock", 32'(ready), 32'd1);
        end
`ifdef PLLCE_LOSS_CNT_EN
        exp_sat = 255;
`else
        exp_sat = 0;
`endif
        chk("loss_saturate", 32'(lock_loss_cnt), 32'(exp_sat));

        // Asynchronous reset mid-operation.
        repeat (3) tick();
        async_reset();
        chk("reset_ready", 32'(ready), 32'd0);
        repeat (5) tick();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
